// File: rtl/usb_pkg.sv
// Shared USB definitions: full-speed line-state encoding and default timing
// values for a 48 MHz clock.
package usb_pkg;

   typedef enum logic [1:0] {
      SE0 = 2'b00,
      K   = 2'b01,
      J   = 2'b10,
      SE1 = 2'b11
   } line_state_t;

   // 2.5 us of SE0 at 48 MHz qualifies as host-signalled bus reset
   localparam int unsigned T_SE0_DEFAULT  = 120;
   // Stretch of usb_reset after the line leaves SE0
   localparam int unsigned T_HOLD_DEFAULT = 16;
   // 3 ms of idle J at 48 MHz means the host has suspended the bus
   localparam int unsigned T_SUSP_DEFAULT = 144000;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/usb_bus_reset_gen_if.sv
// Bus between the line-state synchronizer / SIE and the bus-reset generator.
// master: the reset generator; slave: the logic feeding line state and
// consuming the reset outputs.
interface usb_bus_reset_gen_if;
   import usb_pkg::*;

   line_state_t line_state;
   logic        usb_reset;
   logic        reset_det;
   logic        suspend;

   modport master (
      input  line_state,
      output usb_reset,
      output reset_det,
      output suspend
   );

   modport slave (
      output line_state,
      input  usb_reset,
      input  reset_det,
      input  suspend
   );

endinterface

// File: rtl/usb_idle_timer.sv
// Saturating match counter: counts consecutive cycles with match_i high and
// raises done_o (registered) once LIMIT consecutive matches have been seen.
// clr_i or a non-matching cycle restarts the count. Built only when
// USB_SUSPEND_DETECT_EN is defined; the default build has no idle counter.
`ifdef USB_SUSPEND_DETECT_EN
module usb_idle_timer #(
   parameter int unsigned LIMIT = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic match_i,
   output logic done_o
);

   localparam int unsigned W   = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIM = W'(LIMIT);

   logic [W-1:0] cnt_q, cnt_d;
   logic         done_q, done_d;

   // Next count: restart on clear or mismatch, otherwise count up and stick at LIMIT
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !match_i) begin
         cnt_d = '0;
      end else if (cnt_q != LIM) begin
         cnt_d = cnt_q + W'(1);
      end
      done_d = (cnt_d == LIM);
   end

   // Count and done flag registers
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         done_q <= done_d;
      end
   end

   assign done_o = done_q;

endmodule
`endif

// File: rtl/usb_bus_reset_gen.sv
// Device-side USB bus-reset generator. Qualifies host bus reset (SE0 held for
// T_SE0 cycles), drives a stretched active-high usb_reset for the SIE and a
// one-cycle reset_det pulse per reset episode. EOP-length SE0 is ignored.
// Optional feature macro: USB_SUSPEND_DETECT_EN builds the idle-J suspend
// detector; without it suspend is tied low.
module usb_bus_reset_gen
   import usb_pkg::*;
#(
   parameter int unsigned T_SE0  = T_SE0_DEFAULT,
   parameter int unsigned T_HOLD = T_HOLD_DEFAULT
`ifdef USB_SUSPEND_DETECT_EN
   ,
   parameter int unsigned T_SUSP = T_SUSP_DEFAULT
`endif
) (
   input  logic                clk,
   input  logic                reset,
   usb_bus_reset_gen_if.master bus
);

   localparam int unsigned       CNT_W     = $clog2(max_u(T_SE0, T_HOLD) + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] SE0_LAST  = CNT_W'(T_SE0 - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(T_HOLD - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SE0_CNT,
      ST_BUS_RST,
      ST_HOLD
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             usb_reset_q, usb_reset_d;
   logic             reset_det_q, reset_det_d;
   logic             is_se0;

   // SE1 is an illegal line state and is deliberately lumped with J/K
   assign is_se0 = (bus.line_state == SE0);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_W'(1);
   endfunction

   // Next-state, counter and output decode for the bus-reset FSM
   always_comb begin
      // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
      state_d     = state_q;
      cnt_d       = cnt_q;
      reset_det_d = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (is_se0) begin
               state_d = ST_SE0_CNT;
               cnt_d   = CNT_W'(1);
            end
         end
         ST_SE0_CNT: begin
            if (!is_se0) begin
               // EOP or glitch: too short to be a bus reset
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (cnt_q == SE0_LAST) begin
               state_d     = ST_BUS_RST;
               cnt_d       = '0;
               reset_det_d = 1'b1;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         ST_BUS_RST: begin
            // Host may hold SE0 arbitrarily long; wait for it to release
            if (!is_se0) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            // SE0 returning mid-stretch continues the same episode: no new pulse
            if (is_se0) begin
               state_d = ST_BUS_RST;
               cnt_d   = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = sat_inc(cnt_q);
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      // usb_reset follows the registered state, so it lags qualification by one cycle
      usb_reset_d = (state_q == ST_BUS_RST) || (state_q == ST_HOLD);
   end

   // FSM state, counter and registered outputs
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         usb_reset_q <= 1'b0;
         reset_det_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         usb_reset_q <= usb_reset_d;
         reset_det_q <= reset_det_d;
      end
   end

   assign bus.usb_reset = usb_reset_q;
   assign bus.reset_det = reset_det_q;

`ifdef USB_SUSPEND_DETECT_EN
   logic suspend_w;

   // Idle-J timer; held clear while the bus is in reset
   usb_idle_timer #(
      .LIMIT (T_SUSP)
   ) u_idle_timer (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (usb_reset_q),
      .match_i (bus.line_state == J),
      .done_o  (suspend_w)
   );

   assign bus.suspend = suspend_w;
`else
   assign bus.suspend = 1'b0;
`endif

endmodule

// File: tb/tb_usb_bus_reset_gen.sv
// Self-checking bench for usb_bus_reset_gen: directed scenarios followed by
// random line-state segments, all compared every cycle against a run-length
// reference model of bus-reset episodes and idle-J time.
module tb_usb_bus_reset_gen;
   import usb_pkg::*;

   localparam int unsigned T_SE0  = 120;
   localparam int unsigned T_HOLD = 16;
`ifdef USB_SUSPEND_DETECT_EN
   localparam int unsigned T_SUSP = 1000;
`endif

   logic clk = 1'b0;
   logic reset;

   usb_bus_reset_gen_if bus ();

   usb_bus_reset_gen #(
      .T_SE0  (T_SE0),
      .T_HOLD (T_HOLD)
`ifdef USB_SUSPEND_DETECT_EN
      ,
      .T_SUSP (T_SUSP)
`endif
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Scoreboard counters
   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: an episode opens when SE0 has been seen T_SE0 samples
   // in a row and closes once T_HOLD+1 consecutive non-SE0 samples follow.
   bit active;
   int se0_run;
   int nse0_run;
   int j_run;
   bit exp_usb_reset;
   bit exp_det;
   bit exp_susp;

   // Observation bookkeeping
   int cyc      = 0;
   int det_seen = 0;
   int rises    = 0;
   int det_cyc  = -1;
   int rise_cyc = -1;
   int fall_cyc = -1;
   bit prev_usb_reset = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d (sample %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_update(input line_state_t ls, input bit rst);
      if (rst) begin
         active        = 1'b0;
         se0_run       = 0;
         nse0_run      = 0;
         j_run         = 0;
         exp_usb_reset = 1'b0;
         exp_det       = 1'b0;
         exp_susp      = 1'b0;
         return;
      end
`ifdef USB_SUSPEND_DETECT_EN
      // Idle time only accumulates while usb_reset (pre-edge) is low
      if (exp_usb_reset || ls != J) j_run = 0;
      else                          j_run++;
      exp_susp = (j_run >= T_SUSP);
`else
      exp_susp = 1'b0;
`endif
      // usb_reset reflects the episode as it stood one sample earlier
      exp_usb_reset = active;
      exp_det       = 1'b0;
      if (!active) begin
         if (ls == SE0) begin
            se0_run++;
            if (se0_run == T_SE0) begin
               active   = 1'b1;
               exp_det  = 1'b1;
               se0_run  = 0;
               nse0_run = 0;
            end
         end else begin
            se0_run = 0;
         end
      end else begin
         if (ls == SE0) begin
            nse0_run = 0;
         end else begin
            nse0_run++;
            if (nse0_run == T_HOLD + 1) begin
               active   = 1'b0;
               nse0_run = 0;
               se0_run  = 0;
            end
         end
      end
   endtask

   // One clock: drive on the falling edge, model at the rising edge, compare 1 time unit later
   task automatic step(input line_state_t ls, input bit rst);
      @(negedge clk);
      bus.line_state = ls;
      reset          = rst;
      cyc++;
      @(posedge clk);
      model_update(ls, rst);
      #1;
      check("usb_reset", 32'(bus.usb_reset), 32'(exp_usb_reset));
      check("reset_det", 32'(bus.reset_det), 32'(exp_det));
      check("suspend",   32'(bus.suspend),   32'(exp_susp));
      if (bus.reset_det) begin
         det_seen++;
         det_cyc = cyc;
      end
      if (bus.usb_reset && !prev_usb_reset) begin
         rises++;
         rise_cyc = cyc;
      end
      if (!bus.usb_reset && prev_usb_reset) fall_cyc = cyc;
      prev_usb_reset = bus.usb_reset;
   endtask

   task automatic run(input line_state_t ls, input int n);
      for (int i = 0; i < n; i++) step(ls, 1'b0);
   endtask

   task automatic clear_obs();
      det_seen = 0;
      rises    = 0;
      det_cyc  = -1;
      rise_cyc = -1;
      fall_cyc = -1;
   endtask

   initial begin
      int s0;
      int j0;
      line_state_t ls;

      bus.line_state = J;
      reset          = 1'b1;

      // Reset state: outputs low while reset is held, whatever the line does
      step(SE0, 1'b1);
      step(J, 1'b1);
      step(SE0, 1'b1);
      run(J, 10);

      // EOP-length SE0 must be ignored
      clear_obs();
      run(SE0, 2);
      run(J, 20);
      check("eop_no_det", 32'(det_seen), 32'd0);
      check("eop_no_rst", 32'(rises), 32'd0);

      // One sample short of qualification
      clear_obs();
      run(SE0, T_SE0 - 1);
      run(J, 20);
      check("short_no_det", 32'(det_seen), 32'd0);
      check("short_no_rst", 32'(rises), 32'd0);

      // Long bus reset: pulse on the T_SE0-th SE0 sample, usb_reset one sample later
      clear_obs();
      s0 = cyc + 1;
      run(SE0, 600);
      j0 = cyc + 1;
      run(J, 40);
      check("long_det_once", 32'(det_seen), 32'd1);
      check("long_det_lat",  32'(det_cyc - s0), 32'(T_SE0 - 1));
      check("long_rise_lat", 32'(rise_cyc - s0), 32'(T_SE0));
      // T_HOLD samples of stretch after the first J one, plus the output register stage
      check("long_fall_lat", 32'(fall_cyc - j0), 32'(T_HOLD + 1));

      // SE0 returning during the stretch continues the same episode
      clear_obs();
      run(SE0, T_SE0 + 10);
      run(J, 5);
      run(SE0, 50);
      j0 = cyc + 1;
      run(J, 40);
      check("rearm_det_once", 32'(det_seen), 32'd1);
      check("rearm_one_rise", 32'(rises), 32'd1);
      check("rearm_fall_lat", 32'(fall_cyc - j0), 32'(T_HOLD + 1));

      // Block reset mid-episode; a fresh full SE0 run is required afterwards
      clear_obs();
      run(SE0, T_SE0 + 20);
      step(SE0, 1'b1);
      check("midrst_low", 32'(bus.usb_reset), 32'd0);
      run(SE0, T_SE0 - 1);
      check("midrst_no_redet", 32'(det_seen), 32'd1);
      step(SE0, 1'b0);
      check("midrst_redet", 32'(det_seen), 32'd2);
      run(J, 40);

      // Suspend: exactly T_SUSP J samples set it, one K clears it
      step(K, 1'b0);
      run(J, 999);
      check("susp_not_yet", 32'(bus.suspend), 32'd0);
      step(J, 1'b0);
`ifdef USB_SUSPEND_DETECT_EN
      check("susp_set", 32'(bus.suspend), 32'd1);
`else
      check("susp_set", 32'(bus.suspend), 32'd0);
`endif
      step(K, 1'b0);
      check("susp_clr", 32'(bus.suspend), 32'd0);
      run(J, 999);
      step(K, 1'b0);
      check("susp_short", 32'(bus.suspend), 32'd0);

      // Random line-state segments with occasional block resets
      for (int seg = 0; seg < 80; seg++) begin
         int len;
         if ($urandom_range(0, 19) == 0) begin
            step(line_state_t'($urandom_range(0, 3)), 1'b1);
         end
         if (seg % 2 == 0) begin
            case ($urandom_range(0, 2))
               0:       len = int'($urandom_range(1, 3));
               1:       len = int'($urandom_range(T_SE0 - 8, T_SE0 + 4));
               default: len = int'($urandom_range(T_SE0 + 5, 300));
            endcase
            run(SE0, len);
         end else begin
            ls = line_state_t'($urandom_range(1, 3));
            case ($urandom_range(0, 3))
               0:       len = int'($urandom_range(1, 5));
               1:       len = int'($urandom_range(T_HOLD - 2, T_HOLD + 3));
               2:       len = int'($urandom_range(20, 60));
               default: len = int'($urandom_range(990, 1010));
            endcase
            if (len > 900) ls = J;
            run(ls, len);
         end
      end
      run(J, 40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
